// File: rtl/decode_stage.sv
// Decode stage: turns a 16-bit instruction into registered execute-stage controls, reads the
// register file (write-through bypass), flags back-to-back data hazards, squashes and halts.
module decode_stage #(
    parameter int unsigned DATA_W   = 16,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              inst_valid_i,
    input  logic [15:0]       inst_i,
    input  logic              do_branch_i,
    input  logic              wb_en_i,
    input  logic [3:0]        wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic              is_add_o,
    output logic              is_sub_o,
    output logic              is_and_o,
    output logic              is_or_o,
    output logic              is_gt_o,
    output logic              is_eq_o,
    output logic              is_mem_write_o,
    output logic              is_reg_write_o,
    output logic              is_halt_o,
    output logic              is_branch_o,
    output logic [DATA_W-1:0] val1_o,
    output logic [DATA_W-1:0] val2_o,
    output logic [DATA_W-1:0] val3_o,
    output logic              is_val1_data_hazard_o,
    output logic              is_val2_data_hazard_o,
    output logic              is_mem_data_hazard_o
);

    typedef enum logic [0:0] {StRun, StHalted} state_e;

    typedef struct packed {
        logic is_add;
        logic is_sub;
        logic is_and;
        logic is_or;
        logic is_gt;
        logic is_eq;
        logic is_mem_write;
        logic is_reg_write;
        logic is_halt;
        logic is_branch;
    } ctrl_t;

    localparam logic [3:0] OpAdd = 4'h0;
    localparam logic [3:0] OpSub = 4'h1;
    localparam logic [3:0] OpAnd = 4'h2;
    localparam logic [3:0] OpOr  = 4'h3;
    localparam logic [3:0] OpGt  = 4'h4;
    localparam logic [3:0] OpEq  = 4'h5;
    localparam logic [3:0] OpLdi = 4'h6;
    localparam logic [3:0] OpLd  = 4'h7;
    localparam logic [3:0] OpSt  = 4'h8;
    localparam logic [3:0] OpBeq = 4'h9;
    localparam logic [3:0] OpBgt = 4'hA;
    localparam logic [3:0] OpHlt = 4'hF;

    logic [3:0] op, rd, ra, rb;

    assign op = inst_i[15:12];
    assign rd = inst_i[11:8];
    assign ra = inst_i[7:4];
    assign rb = inst_i[3:0];

    // Register file
    logic [DATA_W-1:0] rf_q [16];
    logic [DATA_W-1:0] ra_val, rb_val, rd_val;

    function automatic logic [DATA_W-1:0] read_port(
        input logic [3:0]        idx,
        input logic [DATA_W-1:0] stored,
        input logic              we,
        input logic [3:0]        wa,
        input logic [DATA_W-1:0] wd
    );
        if (ZERO_REG && idx == 4'd0) begin
            return '0;
        end else if (we && wa == idx) begin
            return wd;
        end
        return stored;
    endfunction

    assign ra_val = read_port(ra, rf_q[ra], wb_en_i, wb_addr_i, wb_data_i);
    assign rb_val = read_port(rb, rf_q[rb], wb_en_i, wb_addr_i, wb_data_i);
    assign rd_val = read_port(rd, rf_q[rd], wb_en_i, wb_addr_i, wb_data_i);

    // Writeback is independent of the decode state: it continues through squash and halt.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_en_i && !(ZERO_REG && wb_addr_i == 4'd0)) begin
            rf_q[wb_addr_i] <= wb_data_i;
        end
    end

    // Decode and hazard tracking
    state_e            state_q, state_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [DATA_W-1:0] val1_q, val1_d;
    logic [DATA_W-1:0] val2_q, val2_d;
    logic [DATA_W-1:0] val3_q, val3_d;
    logic              haz1_q, haz1_d;
    logic              haz2_q, haz2_d;
    logic              haz_mem_q, haz_mem_d;
    logic [3:0]        prev_dst_q, prev_dst_d;
    logic              prev_dst_valid_q, prev_dst_valid_d;
    logic              prev_is_ld_q, prev_is_ld_d;
    logic              uses_a, uses_b, is_ld;

    always_comb begin
        state_d          = state_q;
        ctrl_d           = '0;
        val1_d           = '0;
        val2_d           = '0;
        val3_d           = '0;
        haz1_d           = 1'b0;
        haz2_d           = 1'b0;
        haz_mem_d        = 1'b0;
        prev_dst_d       = prev_dst_q;
        prev_dst_valid_d = 1'b0;
        prev_is_ld_d     = prev_is_ld_q;
        uses_a           = 1'b0;
        uses_b           = 1'b0;
        is_ld            = 1'b0;

        if (state_q == StRun && !do_branch_i && inst_valid_i) begin
            case (op)
                OpAdd, OpSub, OpAnd, OpOr, OpGt, OpEq: begin
                    ctrl_d.is_add       = (op == OpAdd);
                    ctrl_d.is_sub       = (op == OpSub);
                    ctrl_d.is_and       = (op == OpAnd);
                    ctrl_d.is_or        = (op == OpOr);
                    ctrl_d.is_gt        = (op == OpGt);
                    ctrl_d.is_eq        = (op == OpEq);
                    ctrl_d.is_reg_write = 1'b1;
                    val1_d              = ra_val;
                    val2_d              = rb_val;
                    val3_d              = DATA_W'(rd);
                    uses_a              = 1'b1;
                    uses_b              = 1'b1;
                end
                OpLdi: begin
                    ctrl_d.is_add       = 1'b1;
                    ctrl_d.is_reg_write = 1'b1;
                    val1_d              = DATA_W'(inst_i[7:0]);
                    val3_d              = DATA_W'(rd);
                end
                OpLd: begin
                    ctrl_d.is_add       = 1'b1;
                    ctrl_d.is_reg_write = 1'b1;
                    val1_d              = ra_val;
                    val3_d              = DATA_W'(rd);
                    uses_a              = 1'b1;
                    is_ld               = 1'b1;
                end
                OpSt: begin
                    ctrl_d.is_add       = 1'b1;
                    ctrl_d.is_mem_write = 1'b1;
                    val1_d              = ra_val;
                    val3_d              = rd_val;
                    uses_a              = 1'b1;
                end
                OpBeq, OpBgt: begin
                    ctrl_d.is_eq     = (op == OpBeq);
                    ctrl_d.is_gt     = (op == OpBgt);
                    ctrl_d.is_branch = 1'b1;
                    val1_d           = ra_val;
                    val2_d           = rb_val;
                    val3_d           = rd_val;
                    uses_a           = 1'b1;
                    uses_b           = 1'b1;
                end
                OpHlt: begin
                    ctrl_d.is_halt = 1'b1;
                    state_d        = StHalted;
                end
                default: ;
            endcase

            // R0 is never a real producer when it is hardwired to zero.
            haz1_d = uses_a && prev_dst_valid_q && (ra == prev_dst_q)
                     && !(ZERO_REG && ra == 4'd0);
            haz2_d = uses_b && prev_dst_valid_q && (rb == prev_dst_q)
                     && !(ZERO_REG && rb == 4'd0);
            haz_mem_d = prev_is_ld_q && (haz1_d || haz2_d);

            prev_dst_valid_d = ctrl_d.is_reg_write;
            prev_dst_d       = rd;
            prev_is_ld_d     = is_ld;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= StRun;
            ctrl_q           <= '0;
            val1_q           <= '0;
            val2_q           <= '0;
            val3_q           <= '0;
            haz1_q           <= 1'b0;
            haz2_q           <= 1'b0;
            haz_mem_q        <= 1'b0;
            prev_dst_q       <= 4'd0;
            prev_dst_valid_q <= 1'b0;
            prev_is_ld_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            ctrl_q           <= ctrl_d;
            val1_q           <= val1_d;
            val2_q           <= val2_d;
            val3_q           <= val3_d;
            haz1_q           <= haz1_d;
            haz2_q           <= haz2_d;
            haz_mem_q        <= haz_mem_d;
            prev_dst_q       <= prev_dst_d;
            prev_dst_valid_q <= prev_dst_valid_d;
            prev_is_ld_q     <= prev_is_ld_d;
        end
    end

    assign is_add_o              = ctrl_q.is_add;
    assign is_sub_o              = ctrl_q.is_sub;
    assign is_and_o              = ctrl_q.is_and;
    assign is_or_o               = ctrl_q.is_or;
    assign is_gt_o               = ctrl_q.is_gt;
    assign is_eq_o               = ctrl_q.is_eq;
    assign is_mem_write_o        = ctrl_q.is_mem_write;
    assign is_reg_write_o        = ctrl_q.is_reg_write;
    assign is_halt_o             = ctrl_q.is_halt;
    assign is_branch_o           = ctrl_q.is_branch;
    assign val1_o                = val1_q;
    assign val2_o                = val2_q;
    assign val3_o                = val3_q;
    assign is_val1_data_hazard_o = haz1_q;
    assign is_val2_data_hazard_o = haz2_q;
    assign is_mem_data_hazard_o  = haz_mem_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed instruction sequences, a per-cycle reference model of the
// decode rules, and hand-computed expectations for the key scenarios.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_valid;
    logic [15:0] inst;
    logic        do_branch;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;

    logic        is_add, is_sub, is_and, is_or, is_gt, is_eq;
    logic        is_mem_write, is_reg_write, is_halt, is_branch;
    logic [15:0] val1, val2, val3;
    logic        haz1, haz2, haz_mem;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    decode_stage #(
        .DATA_W   (16),
        .ZERO_REG (1'b1)
    ) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .inst_valid_i          (inst_valid),
        .inst_i                (inst),
        .do_branch_i           (do_branch),
        .wb_en_i               (wb_en),
        .wb_addr_i             (wb_addr),
        .wb_data_i             (wb_data),
        .is_add_o              (is_add),
        .is_sub_o              (is_sub),
        .is_and_o              (is_and),
        .is_or_o               (is_or),
        .is_gt_o               (is_gt),
        .is_eq_o               (is_eq),
        .is_mem_write_o        (is_mem_write),
        .is_reg_write_o        (is_reg_write),
        .is_halt_o             (is_halt),
        .is_branch_o           (is_branch),
        .val1_o                (val1),
        .val2_o                (val2),
        .val3_o                (val3),
        .is_val1_data_hazard_o (haz1),
        .is_val2_data_hazard_o (haz2),
        .is_mem_data_hazard_o  (haz_mem)
    );

    // Strobes as a vector: [9]add [8]sub [7]and [6]or [5]gt [4]eq [3]memw [2]regw [1]halt [0]br
    logic [15:0] dut_ops;
    assign dut_ops = {6'b0, is_add, is_sub, is_and, is_or, is_gt, is_eq,
                      is_mem_write, is_reg_write, is_halt, is_branch};

    task automatic chk_w(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %04h want %04h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [15:0] mreg [16];
    bit          m_pv, m_pld, m_halted;
    int          m_pdst;

    logic [15:0] e_ops, e_v1, e_v2, e_v3;
    logic        e_h1, e_h2, e_hm;
    int          m_op, rdi, rai, rbi;
    bit          ua, ub, ld;

    function automatic logic [15:0] rf(input int idx);
        if (idx == 0) return '0;
        if (wb_en && int'(wb_addr) == idx) return wb_data;
        return mreg[idx];
    endfunction

    always @(posedge clk) begin
        if (chk_en && rst_n) begin
            e_ops = '0; e_v1 = '0; e_v2 = '0; e_v3 = '0;
            e_h1 = 1'b0; e_h2 = 1'b0; e_hm = 1'b0;
            ua = 1'b0; ub = 1'b0; ld = 1'b0;
            m_op = int'(inst[15:12]);
            rdi  = int'(inst[11:8]);
            rai  = int'(inst[7:4]);
            rbi  = int'(inst[3:0]);
            if (!m_halted && !do_branch && inst_valid) begin
                if (m_op <= 5) begin
                    e_ops[9-m_op] = 1'b1; e_ops[2] = 1'b1;
                    e_v1 = rf(rai); e_v2 = rf(rbi); e_v3 = 16'(rdi);
                    ua = 1'b1; ub = 1'b1;
                end else if (m_op == 6) begin
                    e_ops[9] = 1'b1; e_ops[2] = 1'b1;
                    e_v1 = {8'h00, inst[7:0]}; e_v3 = 16'(rdi);
                end else if (m_op == 7) begin
                    e_ops[9] = 1'b1; e_ops[2] = 1'b1;
                    e_v1 = rf(rai); e_v3 = 16'(rdi);
                    ua = 1'b1; ld = 1'b1;
                end else if (m_op == 8) begin
                    e_ops[9] = 1'b1; e_ops[3] = 1'b1;
                    e_v1 = rf(rai); e_v3 = rf(rdi);
                    ua = 1'b1;
                end else if (m_op == 9 || m_op == 10) begin
                    e_ops[m_op == 9 ? 4 : 5] = 1'b1; e_ops[0] = 1'b1;
                    e_v1 = rf(rai); e_v2 = rf(rbi); e_v3 = rf(rdi);
                    ua = 1'b1; ub = 1'b1;
                end else if (m_op == 15) begin
                    e_ops[1] = 1'b1;
                    m_halted = 1'b1;
                end
                e_h1 = ua && m_pv && rai == m_pdst && rai != 0;
                e_h2 = ub && m_pv && rbi == m_pdst && rbi != 0;
                e_hm = m_pld && (e_h1 || e_h2);
                m_pv   = e_ops[2];
                m_pdst = rdi;
                m_pld  = ld;
            end else begin
                m_pv = 1'b0;
            end
            if (wb_en && wb_addr != 4'd0) mreg[wb_addr] = wb_data;
            #1;
            chk_w("m_strobes", dut_ops, e_ops);
            chk_w("m_val1", val1, e_v1);
            chk_w("m_val2", val2, e_v2);
            chk_w("m_val3", val3, e_v3);
            chk_b("m_haz1", haz1, e_h1);
            chk_b("m_haz2", haz2, e_h2);
            chk_b("m_hazmem", haz_mem, e_hm);
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mreg[i] = '0;
        m_pv = 1'b0; m_pld = 1'b0; m_halted = 1'b0; m_pdst = 0;
    endtask

    // Apply inputs at negedge, let one posedge pass, return just after it.
    task automatic step(input bit v, input logic [15:0] ins, input bit br,
                        input bit we, input logic [3:0] wa, input logic [15:0] wd);
        @(negedge clk);
        inst_valid = v; inst = ins; do_branch = br;
        wb_en = we; wb_addr = wa; wb_data = wd;
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [15:0] ins);
        step(1'b1, ins, 1'b0, 1'b0, 4'd0, 16'h0000);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0; chk_en = 1'b0;
        inst_valid = 1'b0; inst = 16'h0000; do_branch = 1'b0; wb_en = 1'b0;
        #1;
        chk_w("arst_strobes", dut_ops, 16'h0000);
        chk_w("arst_val1", val1, 16'h0000);
        chk_w("arst_val3", val3, 16'h0000);
        chk_b("arst_haz1", haz1, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; chk_en = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; inst_valid = 1'b0; inst = 16'h0000; do_branch = 1'b0;
        wb_en = 1'b0; wb_addr = 4'd0; wb_data = 16'h0000;
        model_reset();
        #1;
        chk_w("rst_strobes", dut_ops, 16'h0000);
        chk_w("rst_val2", val2, 16'h0000);
        chk_b("rst_hazmem", haz_mem, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1; chk_en = 1'b1;

        for (int i = 1; i < 16; i++) begin
            step(1'b0, 16'h0000, 1'b0, 1'b1, 4'(i), 16'(16'h0100 + i));
        end

        issue(16'h0934);                            // ADD R9,R3,R4
        chk_b("add_is_add", is_add, 1'b1);
        chk_w("add_val1", val1, 16'h0103);
        chk_w("add_val2", val2, 16'h0104);
        chk_w("add_val3", val3, 16'h0009);

        issue(16'h6105);                            // LDI R1,#5
        chk_w("ldi_val1", val1, 16'h0005);
        chk_b("ldi_regw", is_reg_write, 1'b1);
        issue(16'h0211);                            // ADD R2,R1,R1
        chk_w("dep_val3", val3, 16'h0002);
        chk_b("dep_haz1", haz1, 1'b1);
        chk_b("dep_haz2", haz2, 1'b1);
        chk_b("dep_hazmem", haz_mem, 1'b0);

        issue(16'h7340);                            // LD R3,[R4]
        chk_b("ld_haz1", haz1, 1'b0);
        issue(16'h1536);                            // SUB R5,R3,R6
        chk_b("lduse_sub", is_sub, 1'b1);
        chk_b("lduse_haz1", haz1, 1'b1);
        chk_b("lduse_haz2", haz2, 1'b0);
        chk_b("lduse_hazmem", haz_mem, 1'b1);

        step(1'b1, 16'h3870, 1'b0, 1'b1, 4'd7, 16'h00AA);   // OR R8,R7,R0 + wb R7
        chk_w("byp_val1", val1, 16'h00AA);
        chk_w("byp_val2", val2, 16'h0000);
        chk_b("byp_or", is_or, 1'b1);

        step(1'b1, 16'h6001, 1'b0, 1'b1, 4'd0, 16'hFFFF);   // LDI R0,#1 + wb R0 dropped
        chk_w("ldi0_val1", val1, 16'h0001);
        issue(16'h0100);                            // ADD R1,R0,R0
        chk_w("r0_val1", val1, 16'h0000);
        chk_w("r0_val2", val2, 16'h0000);
        chk_b("r0_haz1", haz1, 1'b0);
        chk_b("r0_haz2", haz2, 1'b0);

        issue(16'h8250);                            // ST R2,[R5]
        chk_b("st_memw", is_mem_write, 1'b1);
        chk_b("st_regw", is_reg_write, 1'b0);
        chk_w("st_val1", val1, 16'h0105);
        chk_w("st_val3", val3, 16'h0102);
        issue(16'h0422);                            // ADD R4,R2,R2 after store
        chk_b("afterst_haz1", haz1, 1'b0);

        issue(16'h6109);                            // LDI R1,#9
        step(1'b0, 16'h0211, 1'b0, 1'b0, 4'd0, 16'h0000);   // not valid
        chk_w("inval_strobes", dut_ops, 16'h0000);
        issue(16'h0211);
        chk_b("inval_haz1", haz1, 1'b0);
        issue(16'hC123);                            // unused opcode
        chk_w("unused_strobes", dut_ops, 16'h0000);
        chk_w("unused_val1", val1, 16'h0000);
        issue(16'hA312);                            // BGT

        issue(16'h9412);                            // BEQ R4,R1,R2
        chk_b("beq_eq", is_eq, 1'b1);
        chk_b("beq_br", is_branch, 1'b1);
        chk_w("beq_val3", val3, 16'h0104);
        step(1'b1, 16'hF000, 1'b1, 1'b0, 4'd0, 16'h0000);   // squash with HLT
        chk_w("sq_strobes", dut_ops, 16'h0000);
        issue(16'h6A03);                            // LDI R10,#3
        step(1'b1, 16'h0BAA, 1'b1, 1'b0, 4'd0, 16'h0000);   // squashed
        issue(16'h0BAA);                            // ADD R11,R10,R10
        chk_b("postsq_add", is_add, 1'b1);
        chk_w("postsq_val3", val3, 16'h000B);
        chk_b("postsq_haz1", haz1, 1'b0);

        issue(16'hF000);                            // HLT
        chk_w("hlt_strobes", dut_ops, 16'h0002);
        step(1'b1, 16'h0934, 1'b0, 1'b1, 4'd5, 16'h1234);
        chk_w("halted_strobes", dut_ops, 16'h0000);
        issue(16'h0934);
        chk_b("halted_halt", is_halt, 1'b0);
        chk_w("halted_val1", val1, 16'h0000);

        async_reset();
        issue(16'h6107);                            // LDI R1,#7
        chk_w("rec_val1", val1, 16'h0007);
        async_reset();
        issue(16'h0351);                            // ADD R3,R5,R1
        chk_b("clr_add", is_add, 1'b1);
        chk_w("clr_val1", val1, 16'h0000);
        chk_w("clr_val3", val3, 16'h0003);
        for (int i = 1; i < 16; i++) begin
            issue({8'h00, 4'(i), 4'(i)});
            chk_w("clr_read", val1, 16'h0000);
        end

        step(1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
